// File: rtl/dijkstra_ctrl.sv
// Single-source shortest-path sequencer: owns dist/visited/pred,
// feeds an external min comparator and relaxes edges from a weight RAM.
module dijkstra_ctrl #(
  parameter int N_NODES = 16,
  parameter int DW      = 14,
  parameter int WW      = 8,
  parameter int INF     = 10000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [8:0]    src,
  output logic [4:0]    state,
  output logic [8:0]    counter,
  output logic [DW-1:0] distance,
  output logic          shortest,
  input  logic [DW-1:0] min_distance,
  input  logic [8:0]    New,
  output logic [17:0]   w_addr,
  input  logic [WW-1:0] w_data,
  input  logic [8:0]    rd_node,
  output logic [DW-1:0] rd_dist,
  output logic [8:0]    rd_pred,
  output logic          busy,
  output logic          done
);

  localparam int AW = (N_NODES > 1) ? $clog2(N_NODES) : 1;
  localparam logic [DW-1:0] INF_D = DW'(INF);
  localparam logic [8:0] LAST = 9'(N_NODES - 1);
  localparam logic [8:0] NN = 9'(N_NODES);

  typedef enum logic [4:0] {
    S_IDLE    = 5'd0,
    S_INIT    = 5'd1,
    S_SETSRC  = 5'd2,
    S_PRESCAN = 5'd3,
    S_SCAN    = 5'd4,
    S_SELECT  = 5'd5,
    S_RELAX   = 5'd6,
    S_RWAIT   = 5'd7,
    S_DONE    = 5'd8
  } state_e;

  state_e state_q, state_d;
  logic [8:0] cnt_q, cnt_d;
  logic [8:0] u_q, u_d;
  logic [AW-1:0] src_q, src_d;
  logic [17:0] wa_q, wa_d;
  logic [DW-1:0] dist_q [N_NODES];
  logic [DW-1:0] dist_d [N_NODES];
  logic [8:0] pred_q [N_NODES];
  logic [8:0] pred_d [N_NODES];
  logic [N_NODES-1:0] vis_q, vis_d;

  logic [AW-1:0] ci;
  logic [DW:0] sum;

  assign ci  = cnt_q[AW-1:0];
  // one extra bit so dist[u] + w cannot wrap before the INF check
  assign sum = {1'b0, dist_q[u_q[AW-1:0]]}
             + {{(DW+1-WW){1'b0}}, w_data};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    u_d     = u_q;
    src_d   = src_q;
    wa_d    = wa_q;
    dist_d  = dist_q;
    pred_d  = pred_q;
    vis_d   = vis_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          src_d = src[AW-1:0];
          cnt_d = '0;
          if (src >= NN) begin
            state_d = S_DONE;
            for (int i = 0; i < N_NODES; i++)
              dist_d[i] = INF_D;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        dist_d[ci] = INF_D;
        vis_d[ci]  = 1'b0;
        pred_d[ci] = cnt_q;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_SETSRC;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_SETSRC: begin
        dist_d[src_q] = '0;
        state_d = S_PRESCAN;
      end
      S_PRESCAN: begin
        cnt_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_SELECT;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      S_SELECT: begin
        if (min_distance == INF_D) begin
          state_d = S_DONE;
        end else begin
          u_d   = New;
          vis_d[New[AW-1:0]] = 1'b1;
          cnt_d = '0;
          wa_d  = {New, 9'd0};
          state_d = S_RELAX;
        end
      end
      S_RELAX: state_d = S_RWAIT;
      S_RWAIT: begin
        if (!vis_q[ci] && w_data != '0 &&
            sum < {1'b0, INF_D} &&
            sum < {1'b0, dist_q[ci]}) begin
          dist_d[ci] = sum[DW-1:0];
          pred_d[ci] = u_q;
        end
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_PRESCAN;
        end else begin
          cnt_d   = cnt_q + 9'd1;
          wa_d    = {u_q, cnt_q + 9'd1};
          state_d = S_RELAX;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      u_q     <= '0;
      src_q   <= '0;
      wa_q    <= '0;
      vis_q   <= '0;
      for (int i = 0; i < N_NODES; i++) begin
        dist_q[i] <= INF_D;
        pred_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      u_q     <= u_d;
      src_q   <= src_d;
      wa_q    <= wa_d;
      vis_q   <= vis_d;
      dist_q  <= dist_d;
      pred_q  <= pred_d;
    end
  end

  assign state    = state_q;
  assign counter  = cnt_q;
  assign distance = dist_q[ci];
  assign shortest = vis_q[ci];
  assign w_addr   = wa_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);
  assign rd_dist  = (rd_node < NN) ? dist_q[rd_node[AW-1:0]] : INF_D;
  assign rd_pred  = (rd_node < NN) ? pred_q[rd_node[AW-1:0]] : '0;

endmodule

// File: tb/tb_dijkstra_ctrl.sv
// Bench for dijkstra_ctrl: comparator and weight RAM models,
// reference Dijkstra, per-node readout checks and directed cases.
module tb_dijkstra_ctrl;

  localparam int N   = 48;
  localparam int DW  = 14;
  localparam int WW  = 8;
  localparam int INF = 10000;
  localparam int SPEC_BOUND = N * (2 * N + 3) + N + 2;
  localparam int BOUND = N * (3 * N + 2) + 2 * N + 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [8:0]    src;
  logic [4:0]    state;
  logic [8:0]    counter;
  logic [DW-1:0] distance;
  logic          shortest;
  logic [DW-1:0] min_distance;
  logic [8:0]    New;
  logic [17:0]   w_addr;
  logic [WW-1:0] w_data;
  logic [8:0]    rd_node;
  logic [DW-1:0] rd_dist;
  logic [8:0]    rd_pred;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dijkstra_ctrl #(
    .N_NODES(N), .DW(DW), .WW(WW), .INF(INF)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .src(src),
    .state(state), .counter(counter), .distance(distance),
    .shortest(shortest), .min_distance(min_distance), .New(New),
    .w_addr(w_addr), .w_data(w_data), .rd_node(rd_node),
    .rd_dist(rd_dist), .rd_pred(rd_pred), .busy(busy), .done(done)
  );

  logic [WW-1:0] wmem [N][N];

  // synchronous weight RAM: data one cycle after address
  always @(posedge clk) begin
    if (int'(w_addr[17:9]) < N && int'(w_addr[8:0]) < N)
      w_data <= wmem[int'(w_addr[17:9])][int'(w_addr[8:0])];
    else
      w_data <= '0;
  end

  // min comparator: held at INF outside SCAN, strict compare
  always @(posedge clk or posedge reset) begin
    if (reset || state != 5'd4) begin
      min_distance <= DW'(INF);
      New <= '0;
    end else if (!shortest && distance < min_distance) begin
      min_distance <= distance;
      New <= counter;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_dist [N];
  int exp_pred [N];
  int exp_order [$];
  int sel_q [$];
  bit chk_en = 0;
  bit chk_pred = 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && state == 5'd5 && min_distance != DW'(INF))
      sel_q.push_back(int'(New));
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check($sformatf("rd_dist[%0d]", rd_node), int'(rd_dist),
            exp_dist[int'(rd_node)]);
      if (chk_pred)
        check($sformatf("rd_pred[%0d]", rd_node), int'(rd_pred),
              exp_pred[int'(rd_node)]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_graph();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        wmem[i][j] = '0;
  endtask

  task automatic add_edge(input int a, input int b, input int w);
    wmem[a][b] = WW'(w);
    wmem[b][a] = WW'(w);
  endtask

  task automatic model(input int s);
    bit vis [N];
    int best, sum;
    exp_order.delete();
    for (int i = 0; i < N; i++) begin
      exp_dist[i] = INF;
      exp_pred[i] = i;
      vis[i] = 0;
    end
    chk_pred = (s < N);
    if (s < N) begin
      exp_dist[s] = 0;
      for (int it = 0; it < N; it++) begin
        best = -1;
        for (int i = 0; i < N; i++)
          if (!vis[i] && exp_dist[i] < INF &&
              (best < 0 || exp_dist[i] < exp_dist[best]))
            best = i;
        if (best < 0) break;
        vis[best] = 1;
        exp_order.push_back(best);
        for (int v = 0; v < N; v++) begin
          sum = exp_dist[best] + int'(wmem[best][v]);
          if (!vis[v] && wmem[best][v] != '0 && sum < INF &&
              sum < exp_dist[v]) begin
            exp_dist[v] = sum;
            exp_pred[v] = best;
          end
        end
      end
    end
  endtask

  task automatic pulse(input int s);
    src = 9'(s);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    cyc = 1;
    while (!done && cyc < BOUND) begin
      tick();
      cyc++;
    end
    check({name, "_done_in_budget"}, int'(done), 1);
  endtask

  task automatic readout();
    chk_en = 1;
    for (int i = 0; i < N; i++) begin
      rd_node = 9'(i);
      tick();
    end
    chk_en = 0;
  endtask

  task automatic check_order(input string name);
    check({name, "_sel_count"}, sel_q.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < sel_q.size(); i++)
      check($sformatf("%s_sel%0d", name, i), sel_q[i], exp_order[i]);
  endtask

  task automatic peek(input string name, input int node,
                      input int d, input int p);
    rd_node = 9'(node);
    #1;
    check({name, "_dist"}, int'(rd_dist), d);
    check({name, "_pred"}, int'(rd_pred), p);
  endtask

  task automatic full_run(input string name, input int s, output int cyc);
    model(s);
    sel_q.delete();
    pulse(s);
    wait_done(name, cyc);
    readout();
    check_order(name);
  endtask

  task automatic base_graph(input bit with13);
    clear_graph();
    add_edge(0, 1, 4);
    add_edge(0, 2, 1);
    add_edge(2, 1, 2);
    if (with13) add_edge(1, 3, 5);
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    src = '0;
    rd_node = '0;
    clear_graph();
    tick();
    tick();
    check("rst_state", int'(state), 0);
    check("rst_counter", int'(counter), 0);
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    peek("rst_node5", 5, INF, 0);
    reset = 1'b0;
    tick();

    base_graph(1);
    full_run("basic", 0, cyc);
    check("basic_bound", int'(cyc <= SPEC_BOUND), 1);
    peek("basic_n1", 1, 3, 2);
    peek("basic_n3", 3, 8, 1);
    check("basic_second_sel", sel_q.size() > 1 ? sel_q[1] : -1, 2);

    full_run("src3", 3, cyc);
    peek("src3_n0", 0, 8, 2);

    base_graph(0);
    full_run("discon", 0, cyc);
    check("discon_bound", int'(cyc <= SPEC_BOUND), 1);
    peek("discon_n3", 3, INF, 3);

    clear_graph();
    add_edge(0, 1, 2);
    add_edge(0, 2, 2);
    full_run("tie", 0, cyc);
    check("tie_second_sel", sel_q.size() > 1 ? sel_q[1] : -1, 1);

    clear_graph();
    for (int i = 0; i < 41; i++) add_edge(i, i + 1, 255);
    full_run("chain", 0, cyc);
    peek("chain_n39", 39, 9945, 38);
    peek("chain_n40", 40, INF, 40);

    base_graph(1);
    pulse(0);
    cyc = 0;
    while (state != 5'd6 && cyc < BOUND) begin
      tick();
      cyc++;
    end
    check("relax_reached", int'(state), 6);
    reset = 1'b1;
    #1;
    check("abort_state", int'(state), 0);
    check("abort_busy", int'(busy), 0);
    peek("abort_n0", 0, INF, 0);
    tick();
    reset = 1'b0;
    tick();
    full_run("after_abort", 0, cyc);

    model(0);
    sel_q.delete();
    pulse(0);
    repeat (5) tick();
    check("busy_mid_run", int'(busy), 1);
    pulse(2);
    wait_done("ignore_start", cyc);
    readout();
    check_order("ignore_start");

    model(N);
    pulse(N);
    wait_done("badsrc", cyc);
    check("badsrc_latency", int'(cyc <= 2), 1);
    readout();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
